// File: rtl/avlst_pack_arbiter_if.sv
// Request / end-of-packet / grant bundle shared between the width-converter FIFOs and the packet arbiter.
interface avlst_pack_arbiter_if #(
  parameter int CHAN_NUM = 4
);
  logic [2*CHAN_NUM-1:0] arbit_request;
  logic [CHAN_NUM-1:0]   arbit_eop;
  logic [CHAN_NUM-1:0]   arbit_grant;

  modport master (output arbit_request, output arbit_eop, input arbit_grant);
  modport slave  (input arbit_request, input arbit_eop, output arbit_grant);
endinterface

// File: rtl/avlst_pack_arbiter.sv
// Packet-granular arbiter: critical-over-general round robin, per-grant burst limit and stuck-grant watchdog.
module avlst_pack_arbiter #(
  parameter int CHAN_NUM    = 4,
  parameter int CHAN_WIDTH  = $clog2(CHAN_NUM),
  parameter int MAX_BURST   = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  avlst_pack_arbiter_if.slave   arb,
  output logic                  grant_valid,
  output logic [CHAN_WIDTH-1:0] grant_index,
  output logic                  timeout_pulse,
  output logic [31:0]           timeout_cnt,
  output logic [31:0]           grant_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state, state_nxt;
  logic [CHAN_NUM-1:0]   grant_r, gen_req, crit_req, any_req, cand, pool;
  logic [CHAN_WIDTH-1:0] rr_ptr, winner, scan;
  logic [15:0]           burst;
  logic [31:0]           wd_cnt;
  logic                  win_found, eop_hit, others_req, keep_ok, cont, load, drop, wd_hit;

  function automatic logic [CHAN_WIDTH-1:0] ptr_inc(input logic [CHAN_WIDTH-1:0] p);
    return (int'(p) == CHAN_NUM - 1) ? '0 : p + CHAN_WIDTH'(1);
  endfunction

  always_comb begin
    gen_req  = '0;
    crit_req = '0;
    for (int i = 0; i < CHAN_NUM; i++) begin
      gen_req[i]  = arb.arbit_request[2*i];
      crit_req[i] = arb.arbit_request[2*i+1];
    end
  end

  assign any_req    = gen_req | crit_req;
  assign cand       = (|crit_req) ? crit_req : gen_req;
  assign eop_hit    = (state == GRANT) && arb.arbit_eop[grant_index];
  assign others_req = |(any_req & ~grant_r);

  // The holder may keep the path only while under its burst quota, unless nobody else is waiting.
  assign keep_ok = enable && (|(cand & grant_r)) &&
                   (MAX_BURST == 0 || int'(burst) < MAX_BURST || !others_req);
  assign pool    = !enable ? '0 : (keep_ok ? cand : (cand & ~grant_r));

  always_comb begin
    win_found = 1'b0;
    winner    = '0;
    scan      = '0;
    for (int k = 0; k < CHAN_NUM; k++) begin
      scan = CHAN_WIDTH'((int'(rr_ptr) + k) % CHAN_NUM);
      if (!win_found && pool[scan]) begin
        win_found = 1'b1;
        winner    = scan;
      end
    end
  end

  assign cont   = eop_hit && win_found && (winner == grant_index);
  assign load   = win_found && ((state == IDLE) || eop_hit);
  assign wd_hit = (TIMEOUT_CYC != 0) && (state == GRANT) && !eop_hit &&
                  (wd_cnt == 32'(TIMEOUT_CYC - 1));
  assign drop   = (eop_hit && !win_found) || wd_hit;

  always_comb begin
    state_nxt       = state;
    arb.arbit_grant = grant_r;
    case (state)
      IDLE:    if (load) state_nxt = GRANT;
      GRANT:   if (drop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (eop_hit && !cont) arb.arbit_grant = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r       <= '0;
      grant_index   <= '0;
      rr_ptr        <= '0;
      burst         <= '0;
      wd_cnt        <= '0;
      timeout_pulse <= 1'b0;
      timeout_cnt   <= '0;
      grant_cnt     <= '0;
    end else begin
      timeout_pulse <= wd_hit;
      if (wd_hit && timeout_cnt != '1) timeout_cnt <= timeout_cnt + 32'd1;
      if (eop_hit) grant_cnt <= grant_cnt + 32'd1;
      if (load) begin
        grant_r     <= CHAN_NUM'(1) << winner;
        grant_index <= winner;
        rr_ptr      <= ptr_inc(winner);
        burst       <= cont ? ((burst == '1) ? burst : burst + 16'd1) : 16'd1;
      end else if (drop) begin
        grant_r <= '0;
        if (wd_hit) rr_ptr <= ptr_inc(grant_index);
      end
      wd_cnt <= (state == GRANT && !eop_hit && !wd_hit) ? wd_cnt + 32'd1 : '0;
    end
  end

  assign grant_valid = |grant_r;

endmodule

// File: tb/tb_avlst_pack_arbiter.sv
// Directed scenarios plus randomized traffic checked against a packet-level reference model of the arbiter.
module tb_avlst_pack_arbiter;
  localparam int N    = 4;
  localparam int MAXB = 4;
  localparam int TO   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        grant_valid;
  logic [1:0]  grant_index;
  logic        timeout_pulse;
  logic [31:0] timeout_cnt, grant_cnt;
  int          total = 0;
  int          bad = 0;

  avlst_pack_arbiter_if #(.CHAN_NUM(N)) bus ();

  avlst_pack_arbiter #(.CHAN_NUM(N), .CHAN_WIDTH(2), .MAX_BURST(MAXB), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .arb(bus),
    .grant_valid(grant_valid), .grant_index(grant_index), .timeout_pulse(timeout_pulse),
    .timeout_cnt(timeout_cnt), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  // Model state: who holds the path (-1 none), where the round robin resumes, packets in this grant, cycles since last eop.
  int          m_holder = -1, m_rr = 0, m_burst = 0, m_wd = 0, m_idx = 0;
  bit          m_tp = 0;
  int unsigned m_tcnt = 0, m_gcnt = 0;
  int          n_holder = -1, n_rr = 0, n_burst = 0, n_wd = 0, n_idx = 0;
  bit          n_tp = 0;
  int unsigned n_tcnt = 0, n_gcnt = 0;
  logic [3:0]  exp_grant;
  logic        exp_valid, exp_tp;
  logic [1:0]  exp_index;
  logic [31:0] exp_tcnt, exp_gcnt;

  function automatic int pick(input bit [N-1:0] set, input int from);
    for (int k = 0; k < N; k++) if (set[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  task automatic model_eval(input logic r, input logic en, input logic [2*N-1:0] req, input logic [N-1:0] eop);
    bit [N-1:0] gen, crit, cls, pool;
    bit others, keep_ok;
    int w;
    exp_valid = (m_holder >= 0);
    exp_grant = (m_holder >= 0) ? 4'(1 << m_holder) : 4'b0000;
    exp_index = 2'(m_idx);
    exp_tp    = m_tp;
    exp_tcnt  = m_tcnt;
    exp_gcnt  = m_gcnt;
    n_holder = m_holder; n_rr = m_rr; n_burst = m_burst; n_wd = m_wd; n_idx = m_idx;
    n_tp = 0; n_tcnt = m_tcnt; n_gcnt = m_gcnt;
    if (r) begin
      n_holder = -1; n_rr = 0; n_burst = 0; n_wd = 0; n_idx = 0; n_tcnt = 0; n_gcnt = 0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      gen[i]  = req[2*i];
      crit[i] = req[2*i+1];
    end
    cls = (crit != 0) ? crit : gen;
    if (m_holder < 0) begin
      w = en ? pick(cls, m_rr) : -1;
      if (w >= 0) begin
        n_holder = w; n_idx = w; n_rr = (w + 1) % N; n_burst = 1; n_wd = 0;
      end
    end else if (eop[m_holder]) begin
      n_gcnt = m_gcnt + 1;
      others = 0;
      for (int i = 0; i < N; i++) if (i != m_holder && (gen[i] || crit[i])) others = 1;
      keep_ok = en && cls[m_holder] && (MAXB == 0 || m_burst < MAXB || !others);
      pool = cls;
      if (!keep_ok) pool[m_holder] = 1'b0;
      w = en ? pick(pool, m_rr) : -1;
      n_wd = 0;
      if (w == m_holder) begin
        n_burst = m_burst + 1; n_rr = (w + 1) % N;
      end else begin
        exp_grant = 4'b0000;
        if (w >= 0) begin
          n_holder = w; n_idx = w; n_rr = (w + 1) % N; n_burst = 1;
        end else begin
          n_holder = -1;
        end
      end
    end else if (m_wd == TO - 1) begin
      n_tp = 1;
      if (m_tcnt != 32'hFFFF_FFFF) n_tcnt = m_tcnt + 1;
      n_rr = (m_holder + 1) % N;
      n_holder = -1;
      n_wd = 0;
    end else begin
      n_wd = m_wd + 1;
    end
  endtask

  task automatic tick(input logic r, input logic en, input logic [2*N-1:0] req, input logic [N-1:0] eop);
    @(posedge clk);
    m_holder = n_holder; m_rr = n_rr; m_burst = n_burst; m_wd = n_wd; m_idx = n_idx;
    m_tp = n_tp; m_tcnt = n_tcnt; m_gcnt = n_gcnt;
    #1;
    rst = r;
    enable = en;
    bus.arbit_request = req;
    bus.arbit_eop = eop;
    model_eval(r, en, req, eop);
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 8'h00, 4'h0);
    tick(1'b1, 1'b0, 8'h00, 4'h0);
    tick(1'b0, 1'b0, 8'h00, 4'h0);
    total++; if (bus.arbit_grant !== 4'b0000) begin bad++; $display("[TB] FAIL reset_grant got=%b want=0000", bus.arbit_grant); end
    total++; if (grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", grant_valid); end
    total++; if (grant_index !== 2'd0) begin bad++; $display("[TB] FAIL reset_index got=%0d want=0", grant_index); end
    total++; if (timeout_pulse !== 1'b0) begin bad++; $display("[TB] FAIL reset_tpulse got=%b want=0", timeout_pulse); end
    total++; if (timeout_cnt !== 32'd0) begin bad++; $display("[TB] FAIL reset_tcnt got=%0d want=0", timeout_cnt); end
    total++; if (grant_cnt !== 32'd0) begin bad++; $display("[TB] FAIL reset_gcnt got=%0d want=0", grant_cnt); end
  endtask

  task automatic test_single_packet();
    tick(1'b1, 1'b0, 8'h00, 4'h0);
    tick(1'b0, 1'b1, 8'h04, 4'h0);
    total++; if (bus.arbit_grant !== 4'b0000) begin bad++; $display("[TB] FAIL single_c0 got=%b want=0000", bus.arbit_grant); end
    for (int c = 1; c < 10; c++) begin
      tick(1'b0, 1'b1, 8'h04, 4'h0);
      total++; if (bus.arbit_grant !== 4'b0010) begin bad++; $display("[TB] FAIL single_hold c=%0d got=%b want=0010", c, bus.arbit_grant); end
    end
    tick(1'b0, 1'b1, 8'h00, 4'b0010);
    total++; if (bus.arbit_grant !== 4'b0000) begin bad++; $display("[TB] FAIL single_eop got=%b want=0000", bus.arbit_grant); end
    tick(1'b0, 1'b1, 8'h00, 4'h0);
    total++; if (grant_cnt !== 32'd1) begin bad++; $display("[TB] FAIL single_gcnt got=%0d want=1", grant_cnt); end
    total++; if (grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_idle got=%b want=0", grant_valid); end
  endtask

  task automatic test_alternate();
    logic [3:0] want;
    tick(1'b1, 1'b0, 8'h00, 4'h0);
    tick(1'b0, 1'b1, 8'h11, 4'h0);
    total++; if (bus.arbit_grant !== 4'b0000) begin bad++; $display("[TB] FAIL alt_c0 got=%b want=0000", bus.arbit_grant); end
    want = 4'b0001;
    for (int p = 0; p < 8; p++) begin
      tick(1'b0, 1'b1, 8'h11, 4'h0);
      total++; if (bus.arbit_grant !== want) begin bad++; $display("[TB] FAIL alt_grant p=%0d got=%b want=%b", p, bus.arbit_grant, want); end
      total++; if (grant_index !== ((want == 4'b0001) ? 2'd0 : 2'd2)) begin bad++; $display("[TB] FAIL alt_index p=%0d got=%0d want=%0d", p, grant_index, (want == 4'b0001) ? 0 : 2); end
      tick(1'b0, 1'b1, 8'h11, 4'h0);
      tick(1'b0, 1'b1, 8'h11, want);
      total++; if (bus.arbit_grant !== 4'b0000) begin bad++; $display("[TB] FAIL alt_eop p=%0d got=%b want=0000", p, bus.arbit_grant); end
      want = (want == 4'b0001) ? 4'b0100 : 4'b0001;
    end
    tick(1'b0, 1'b1, 8'h00, 4'h0);
    total++; if (grant_cnt !== 32'd8) begin bad++; $display("[TB] FAIL alt_gcnt got=%0d want=8", grant_cnt); end
  endtask

  task automatic test_continuous();
    tick(1'b1, 1'b0, 8'h00, 4'h0);
    tick(1'b0, 1'b1, 8'h40, 4'h0);
    for (int p = 0; p < 6; p++) begin
      tick(1'b0, 1'b1, 8'h40, 4'h0);
      total++; if (bus.arbit_grant !== 4'b1000) begin bad++; $display("[TB] FAIL cont_mid p=%0d got=%b want=1000", p, bus.arbit_grant); end
      tick(1'b0, 1'b1, 8'h40, 4'b1000);
      total++; if (bus.arbit_grant !== 4'b1000) begin bad++; $display("[TB] FAIL cont_eop p=%0d got=%b want=1000", p, bus.arbit_grant); end
    end
    tick(1'b0, 1'b1, 8'h40, 4'h0);
    total++; if (grant_cnt !== 32'd6) begin bad++; $display("[TB] FAIL cont_gcnt got=%0d want=6", grant_cnt); end
  endtask

  task automatic test_critical_preempt();
    tick(1'b1, 1'b0, 8'h00, 4'h0);
    tick(1'b0, 1'b1, 8'h01, 4'h0);
    for (int c = 1; c < 4; c++) tick(1'b0, 1'b1, 8'h01, 4'h0);
    for (int c = 4; c < 6; c++) begin
      tick(1'b0, 1'b1, 8'h21, 4'h0);
      total++; if (bus.arbit_grant !== 4'b0001) begin bad++; $display("[TB] FAIL crit_keep c=%0d got=%b want=0001", c, bus.arbit_grant); end
    end
    tick(1'b0, 1'b1, 8'h21, 4'b0001);
    total++; if (bus.arbit_grant !== 4'b0000) begin bad++; $display("[TB] FAIL crit_eop got=%b want=0000", bus.arbit_grant); end
    tick(1'b0, 1'b1, 8'h21, 4'h0);
    total++; if (bus.arbit_grant !== 4'b0100) begin bad++; $display("[TB] FAIL crit_switch got=%b want=0100", bus.arbit_grant); end
    total++; if (grant_index !== 2'd2) begin bad++; $display("[TB] FAIL crit_index got=%0d want=2", grant_index); end
  endtask

  task automatic test_timeout();
    tick(1'b1, 1'b0, 8'h00, 4'h0);
    tick(1'b0, 1'b1, 8'h14, 4'h0);
    for (int c = 1; c <= 16; c++) begin
      tick(1'b0, 1'b1, 8'h14, 4'h0);
      total++; if (bus.arbit_grant !== 4'b0010) begin bad++; $display("[TB] FAIL to_hold c=%0d got=%b want=0010", c, bus.arbit_grant); end
    end
    tick(1'b0, 1'b1, 8'h14, 4'h0);
    total++; if (bus.arbit_grant !== 4'b0000) begin bad++; $display("[TB] FAIL to_drop got=%b want=0000", bus.arbit_grant); end
    total++; if (timeout_pulse !== 1'b1) begin bad++; $display("[TB] FAIL to_pulse got=%b want=1", timeout_pulse); end
    total++; if (timeout_cnt !== 32'd1) begin bad++; $display("[TB] FAIL to_cnt got=%0d want=1", timeout_cnt); end
    tick(1'b0, 1'b1, 8'h14, 4'h0);
    total++; if (bus.arbit_grant !== 4'b0100) begin bad++; $display("[TB] FAIL to_next got=%b want=0100", bus.arbit_grant); end
    total++; if (timeout_pulse !== 1'b0) begin bad++; $display("[TB] FAIL to_pulse_end got=%b want=0", timeout_pulse); end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 1'b0, 8'h00, 4'h0);
    tick(1'b0, 1'b1, 8'h01, 4'h0);
    tick(1'b0, 1'b1, 8'h01, 4'h0);
    tick(1'b0, 1'b1, 8'h05, 4'h0);
    total++; if (bus.arbit_grant !== 4'b0001) begin bad++; $display("[TB] FAIL rmid_pre got=%b want=0001", bus.arbit_grant); end
    tick(1'b1, 1'b1, 8'h05, 4'h0);
    tick(1'b0, 1'b1, 8'h05, 4'h0);
    total++; if (bus.arbit_grant !== 4'b0000) begin bad++; $display("[TB] FAIL rmid_grant got=%b want=0000", bus.arbit_grant); end
    total++; if (grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL rmid_valid got=%b want=0", grant_valid); end
    tick(1'b0, 1'b1, 8'h05, 4'h0);
    total++; if (bus.arbit_grant !== 4'b0001) begin bad++; $display("[TB] FAIL rmid_first got=%b want=0001", bus.arbit_grant); end
  endtask

  task automatic test_random();
    logic [7:0]  req;
    logic [3:0]  eop;
    logic        en, r;
    logic [71:0] got, want;
    tick(1'b1, 1'b0, 8'h00, 4'h0);
    req = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) begin
        for (int i = 0; i < N; i++) begin
          req[2*i]   = ($urandom_range(1) == 1);
          req[2*i+1] = ($urandom_range(7) == 0);
        end
      end
      en  = ($urandom_range(15) != 0);
      r   = (c % 1000 == 999);
      eop = ($urandom_range(5) == 0) ? 4'($urandom_range(15)) : 4'h0;
      if (n_holder >= 0 && $urandom_range((c < 1500) ? 2 : 11) == 0) eop[n_holder] = 1'b1;
      tick(r, en, req, eop);
      got  = {bus.arbit_grant, grant_valid, grant_index, timeout_pulse, timeout_cnt, grant_cnt};
      want = {exp_grant, exp_valid, exp_index, exp_tp, exp_tcnt, exp_gcnt};
      total++; if (got !== want) begin bad++; $display("[TB] FAIL random c=%0d got=%h want=%h", c, got, want); end
      total++; if ($countones(bus.arbit_grant) > 1) begin bad++; $display("[TB] FAIL onehot c=%0d got=%b want=at_most_one", c, bus.arbit_grant); end
    end
  endtask

  initial begin
    bus.arbit_request = '0;
    bus.arbit_eop = '0;
    test_reset();
    test_single_packet();
    test_alternate();
    test_continuous();
    test_critical_preempt();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
